// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch sequencer.
//            - fetch_state_e : sequencer states (IDLE, RUN, HALT)
//            - FIFO_DEPTH    : depth of the decode-facing instruction queue
//            - INSTR_W       : instruction word width
//            - DEFAULT_HALT_INSTR : word that stops fetching by default
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int INSTR_W    = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Two-entry FIFO of {pc, instruction} pairs feeding decode.
//            Flush empties the queue and wins over a same-cycle push.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            flush_i           - discard all entries
//            push_i, push_pc_i, push_instr_i - write one entry
//            pop_i             - remove head entry
//            head_pc_o, head_instr_o - head entry contents
//            count_o           - number of stored entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    output logic [ADDR_W-1:0]  head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [1:0]         count_o
);

    logic [ADDR_W-1:0]  pc_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_q [FIFO_DEPTH];
    // One-bit pointers: the queue is exactly two entries deep.
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                pc_q[wr_ptr_q]    <= push_pc_i;
                instr_q[wr_ptr_q] <= push_instr_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_pc_o    = pc_q[rd_ptr_q];
    assign head_instr_o = instr_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : Fetch sequencer. Owns the PC, issues word reads to a synchronous
//            instruction ROM (1-cycle latency), buffers responses in a
//            two-entry queue and presents them to decode over valid/ready.
//            Handles branch redirects and stops fetching at a halt word.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            enable_i              - leave IDLE and start fetching
//            imem_req_o/imem_addr_o- ROM read strobe and word address
//            imem_rdata_i          - ROM data, valid the cycle after a request
//            instr_o/instr_pc_o/instr_valid_o, instr_ready_i - decode handshake
//            redirect_valid_i/redirect_pc_i - taken branch / jump target
//            halted_o              - halted and all instructions delivered
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    output logic               imem_req_o,
    output logic [ADDR_W-3:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               halted_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]         q_count;
    logic [ADDR_W-1:0]  q_head_pc;
    logic [INSTR_W-1:0] q_head_instr;

    logic arrive;
    logic use_bypass;
    logic out_valid;
    logic take;
    logic q_push;
    logic q_pop;
    logic halt_hit;
    logic credit_ok;
    logic issue;

    // Redirect targets are word aligned; the low bits carry no information.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // A response is only kept while running; after the halt word has been
    // seen anything still returning from memory is discarded.
    assign arrive     = inflight_q && (state_q == ST_RUN);
    // With an empty queue the arriving word is shown to decode directly, so
    // a request in cycle N is visible to decode in cycle N+1.
    assign use_bypass = arrive && (q_count == 2'd0);
    assign out_valid  = (q_count != 2'd0) || arrive;
    assign take       = out_valid && instr_ready_i;
    assign q_pop      = take && (q_count != 2'd0);
    assign q_push     = arrive && !(take && (q_count == 2'd0));
    assign halt_hit   = arrive && (imem_rdata_i == HALT_INSTR);

    // Stored entries plus the in-flight word never exceed the queue depth.
    assign credit_ok  = ({1'b0, q_count} + {2'b00, inflight_q}) < 3'(FIFO_DEPTH);
    // No speculative fetch past a halt word.
    assign issue      = (state_q == ST_RUN) && credit_ok && !redirect_valid_i && !halt_hit;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (issue) begin
            pc_d          = pc_q + ADDR_W'(4);
            inflight_pc_d = pc_q;
        end

        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_RUN;
            ST_RUN:  if (halt_hit) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything; in IDLE it only preloads the PC.
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid_i),
        .push_i       (q_push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (imem_rdata_i),
        .pop_i        (q_pop),
        .head_pc_o    (q_head_pc),
        .head_instr_o (q_head_instr),
        .count_o      (q_count)
    );

    assign imem_req_o    = issue;
    assign imem_addr_o   = pc_q[ADDR_W-1:2];
    assign instr_valid_o = out_valid;
    assign instr_o       = use_bypass ? imem_rdata_i  : q_head_instr;
    assign instr_pc_o    = use_bypass ? inflight_pc_q : q_head_pc;
    assign halted_o      = (state_q == ST_HALT) && (q_count == 2'd0);

endmodule : instr_fetch_ctrl
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Purpose  : Self-checking bench for instr_fetch_ctrl with a synchronous ROM
//            model and a program-order reference for randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int checks;
    int errors;

    logic [31:0] rom [0:1023];

    instr_fetch_ctrl #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_0000),
        .HALT_INSTR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_i         (enable),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .halted_o         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (imem_req) imem_rdata <= rom[imem_addr[9:0]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_rom_pattern();
        for (int i = 0; i < 1024; i++)
            rom[i] = 32'h3800_0000 + (((i + 1) & 32'h1F) << 21) + (i + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, halted} !== '0) begin
            errors++;
            $display("FAIL reset_values got req=%0b addr=%0h instr=%0h pc=%0h valid=%0b halted=%0b exp all zero",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, halted);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_fetch got req=%0b valid=%0b exp 0 0", imem_req, instr_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_stream();
        fill_rom_pattern();
        do_reset();
        instr_ready = 1'b1;
        enable      = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stream_enable_cycle_req got %0b exp 0", imem_req);
        end
        next_cycle();
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 30'(k)) begin
                errors++;
                $display("FAIL stream_req[%0d] got req=%0b addr=%0h exp 1 %0h", k, imem_req, imem_addr, k);
            end
            checks++;
            if (k == 0) begin
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_first_valid got %0b exp 0", instr_valid);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 32'((k - 1) * 4) || instr !== rom[k - 1]) begin
                errors++;
                $display("FAIL stream_out[%0d] got v=%0b pc=%0h instr=%0h exp 1 %0h %0h",
                         k, instr_valid, instr_pc, instr, (k - 1) * 4, rom[k - 1]);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int          nreq;
        int          got;
        logic [31:0] exp_pc;
        fill_rom_pattern();
        do_reset();
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        nreq = 0;
        @(negedge clk);
        if (imem_req) nreq++;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== rom[0]) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b pc=%0h instr=%0h exp 1 0 %0h", k, instr_valid, instr_pc, instr, rom[0]);
            end
            if (k >= 1) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_req_low[%0d] got %0b exp 0", k, imem_req);
                end
            end
            next_cycle();
        end
        checks++;
        if (nreq !== 2) begin
            errors++;
            $display("FAIL bp_request_count got %0d exp 2", nreq);
        end
        instr_ready = 1'b1;
        exp_pc = 32'h0;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== rom[exp_pc[11:2]]) begin
                    errors++;
                    $display("FAIL bp_release_order got pc=%0h instr=%0h exp %0h %0h", instr_pc, instr, exp_pc, rom[exp_pc[11:2]]);
                end
                exp_pc += 32'd4;
                got++;
            end
            next_cycle();
        end
        checks++;
        if (got !== 6) begin
            errors++;
            $display("FAIL bp_release_throughput got %0d exp 6", got);
        end
    endtask

    task automatic test_redirect();
        fill_rom_pattern();
        do_reset();
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        repeat (4) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_full_state got v=%0b req=%0b exp 1 0", instr_valid, imem_req);
        end
        next_cycle();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'h40) begin
            errors++;
            $display("FAIL redir_next_cycle got v=%0b req=%0b addr=%0h exp 0 1 40", instr_valid, imem_req, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== rom[10'h40]) begin
            errors++;
            $display("FAIL redir_target got v=%0b pc=%0h instr=%0h exp 1 100 %0h", instr_valid, instr_pc, instr, rom[10'h40]);
        end
    endtask

    task automatic test_halt();
        logic        found;
        logic [29:0] maxaddr;
        int          k;
        fill_rom_pattern();
        rom[4] = 32'h0000_0000;
        do_reset();
        instr_ready = 1'b1;
        enable      = 1'b1;
        next_cycle();
        enable  = 1'b0;
        found   = 1'b0;
        maxaddr = '0;
        k       = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            if (imem_req && imem_addr > maxaddr) maxaddr = imem_addr;
            if (instr_valid && instr_pc == 32'h10) begin
                found = 1'b1;
                checks++;
                if (instr !== 32'h0 || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_word_delivery got instr=%0h halted=%0b exp 0 0", instr, halted);
                end
            end
            next_cycle();
            k++;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL halt_word_timeout got found=%0b exp 1", found);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_raised got halted=%0b v=%0b exp 1 0", halted, instr_valid);
        end
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            @(negedge clk);
            if (imem_req && imem_addr > maxaddr) maxaddr = imem_addr;
        end
        checks++;
        if (maxaddr > 30'd5) begin
            errors++;
            $display("FAIL halt_no_extra_fetch got maxaddr=%0h exp <=5", maxaddr);
        end
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h8 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume_req got req=%0b addr=%0h halted=%0b exp 1 8 0", imem_req, imem_addr, halted);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== rom[8]) begin
            errors++;
            $display("FAIL halt_resume_out got v=%0b pc=%0h instr=%0h exp 1 20 %0h", instr_valid, instr_pc, instr, rom[8]);
        end
        fill_rom_pattern();
    endtask

    task automatic test_reset_midstream();
        fill_rom_pattern();
        do_reset();
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_prefill got v=%0b pc=%0h exp 1 0", instr_valid, instr_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, halted} !== '0) begin
            errors++;
            $display("FAIL midrst_async_values got req=%0b addr=%0h instr=%0h pc=%0h v=%0b halted=%0b exp all zero",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, halted);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle got req=%0b v=%0b exp 0 0", imem_req, instr_valid);
            end
            next_cycle();
        end
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL midrst_refetch got req=%0b addr=%0h exp 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        fill_rom_pattern();
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_idle_load got req=%0b v=%0b addr=%0h exp 0 0 3fffffff", imem_req, instr_valid, imem_addr);
        end
        next_cycle();
        enable = 1'b1;
        next_cycle();
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_top_req got req=%0b addr=%0h exp 1 3fffffff", imem_req, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL wrap_next_req got req=%0b addr=%0h exp 1 0", imem_req, imem_addr);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== rom[1023]) begin
            errors++;
            $display("FAIL wrap_top_out got v=%0b pc=%0h instr=%0h exp 1 fffffffc %0h", instr_valid, instr_pc, instr, rom[1023]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== rom[0]) begin
            errors++;
            $display("FAIL wrap_zero_out got v=%0b pc=%0h instr=%0h exp 1 0 %0h", instr_valid, instr_pc, instr, rom[0]);
        end
    endtask

    // Reference: decode must see consecutive words in program order starting
    // at 0 or at the most recent redirect target, each equal to the ROM word.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic        prev_hold;
        logic        expect_bubble;
        logic        redir;
        int          deliveries;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom | 32'h1;
        do_reset();
        enable = 1'b1;
        next_cycle();
        enable        = 1'b0;
        exp_pc        = 32'h0;
        prev_hold     = 1'b0;
        expect_bubble = 1'b0;
        prev_pc       = 32'h0;
        prev_instr    = 32'h0;
        deliveries    = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            redir          = ($urandom_range(0, 29) == 0);
            tgt            = 32'($urandom_range(0, 4095));
            redirect_valid = redir;
            redirect_pc    = tgt;
            @(negedge clk);
            if (expect_bubble) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_redirect_bubble cycle %0d got v=%0b exp 0", c, instr_valid);
                end
            end
            if (prev_hold) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_stall_stable cycle %0d got v=%0b pc=%0h instr=%0h exp 1 %0h %0h",
                             c, instr_valid, instr_pc, instr, prev_pc, prev_instr);
                end
            end
            checks++;
            if (halted !== 1'b0) begin
                errors++;
                $display("FAIL rnd_not_halted cycle %0d got %0b exp 0", c, halted);
            end
            if (instr_valid === 1'b1 && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== rom[exp_pc[11:2]]) begin
                    errors++;
                    $display("FAIL rnd_delivery cycle %0d got pc=%0h instr=%0h exp %0h %0h",
                             c, instr_pc, instr, exp_pc, rom[exp_pc[11:2]]);
                end
                exp_pc += 32'd4;
                deliveries++;
            end
            prev_hold  = (instr_valid === 1'b1) && !instr_ready && !redir;
            prev_pc    = instr_pc;
            prev_instr = instr;
            if (redir) exp_pc = {tgt[31:2], 2'b00};
            expect_bubble = redir;
            next_cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (deliveries < 1000) begin
            errors++;
            $display("FAIL rnd_progress got %0d deliveries exp >=1000", deliveries);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fill_rom_pattern();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got time=%0t exp finish earlier", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_instr_fetch_ctrl
`default_nettype wire
